multi_channel_watchdog: RTL and testbench

MULTI_CHANNEL_WATCHDOG -- requirements
Module: multi_channel_watchdog

---
 rtl/wd_pkg.sv | 55 +++++
 rtl/wd_channel.sv | 137 +++++++++++++
 rtl/multi_channel_watchdog.sv | 68 ++++++
 tb/tb_multi_channel_watchdog.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/wd_pkg.sv
// -----------------------------------------------------------------------------
// wd_pkg
// Shared definitions for the multi-channel watchdog:
//   - wd_state_e    : per-channel FSM state encoding
//   - wd_params_ok  : parameter legality check, evaluated at elaboration time
// -----------------------------------------------------------------------------
package wd_pkg;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_WARN     = 2'd2,
    ST_TRIPPED  = 2'd3
  } wd_state_e;

  // Returns 1 when the parameter set describes a legal watchdog configuration.
  // TIMEOUT must fit in CNT_W bits because the counter parks at TIMEOUT.
  function automatic bit wd_params_ok(
    input int unsigned n_ch,
    input int unsigned cnt_w,
    input int unsigned timeout,
    input int unsigned warn_thresh,
    input int unsigned window_min
  );
    bit ok;
    ok = 1'b1;
    if ((n_ch < 32'd1) || (n_ch > 32'd32)) begin
      ok = 1'b0;
    end else begin
      ok = ok;
    end
    if ((cnt_w < 32'd2) || (timeout < 32'd2)) begin
      ok = 1'b0;
    end else begin
      ok = ok;
    end
    if ((cnt_w < 32'd32) && (timeout > ((32'd1 << cnt_w) - 32'd1))) begin
      ok = 1'b0;
    end else begin
      ok = ok;
    end
    if ((warn_thresh < 32'd1) || (warn_thresh >= timeout)) begin
      ok = 1'b0;
    end else begin
      ok = ok;
    end
    if (window_min >= timeout) begin
      ok = 1'b0;
    end else begin
      ok = ok;
    end
    return ok;
  endfunction

endpackage

// File: rtl/wd_channel.sv
// -----------------------------------------------------------------------------
// wd_channel
// One watchdog channel: heartbeat edge detector, timeout counter and
// DISABLED/ARMED/WARN/TRIPPED state machine.
// Ports:
//   i_clk         : system clock, rising edge
//   i_rstn        : synchronous active-low reset
//   i_enable      : channel enable (level)
//   i_heartbeat   : kick input, rising edge is a kick
//   i_clear       : trip clear (level)
//   o_warning     : high while in WARN
//   o_triggered   : high while in TRIPPED
//   o_early_fault : sticky flag, trip caused by a kick inside the window
// -----------------------------------------------------------------------------
module wd_channel
  import wd_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TIMEOUT     = 1000,
  parameter int unsigned WARN_THRESH = 800,
  parameter int unsigned WINDOW_MIN  = 0
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_enable,
  input  logic i_heartbeat,
  input  logic i_clear,
  output logic o_warning,
  output logic o_triggered,
  output logic o_early_fault
);

  // Parameters brought to counter width once, so every compare is CNT_W wide.
  localparam logic [CNT_W-1:0] C_TMO    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] C_TMO_M1 = CNT_W'(TIMEOUT - 32'd1);
  localparam logic [CNT_W-1:0] C_WARN   = CNT_W'(WARN_THRESH);
  localparam logic [CNT_W-1:0] C_WIN    = CNT_W'(WINDOW_MIN);
  localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(32'd1);
  localparam logic             C_WIN_EN = (WINDOW_MIN > 32'd0);

  wd_state_e        r_state;
  wd_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_hb_prev;
  logic             r_early;
  logic             w_early_nxt;
  logic             w_kick;
  logic             w_too_early;

  assign w_kick      = i_heartbeat & ~r_hb_prev;
  assign w_cnt_inc   = r_cnt + C_ONE;
  assign w_too_early = C_WIN_EN & (r_cnt < C_WIN);

  // Next-state and next-counter logic for the channel FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_early_nxt = r_early;
    case (r_state)
      ST_DISABLED: begin
        w_cnt_nxt   = '0;
        w_early_nxt = 1'b0;
        if (i_enable) begin
          w_state_nxt = ST_ARMED;
        end else begin
          w_state_nxt = ST_DISABLED;
        end
      end
      ST_ARMED, ST_WARN: begin
        if (!i_enable) begin
          w_state_nxt = ST_DISABLED;
          w_cnt_nxt   = '0;
        end else if (w_kick && w_too_early) begin
          w_state_nxt = ST_TRIPPED;
          w_cnt_nxt   = C_TMO;
          w_early_nxt = 1'b1;
        end else if (w_kick) begin
          // A kick on the last counting cycle still wins over the trip.
          w_state_nxt = ST_ARMED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == C_TMO_M1) begin
          w_state_nxt = ST_TRIPPED;
          w_cnt_nxt   = C_TMO;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc >= C_WARN) begin
            w_state_nxt = ST_WARN;
          end else begin
            w_state_nxt = r_state;
          end
        end
      end
      ST_TRIPPED: begin
        // Clear outranks any kick; enable alone never releases a trip.
        if (i_clear) begin
          w_cnt_nxt   = '0;
          w_early_nxt = 1'b0;
          if (i_enable) begin
            w_state_nxt = ST_ARMED;
          end else begin
            w_state_nxt = ST_DISABLED;
          end
        end else begin
          w_state_nxt = ST_TRIPPED;
          w_cnt_nxt   = C_TMO;
        end
      end
      default: begin
        w_state_nxt = ST_DISABLED;
        w_cnt_nxt   = '0;
        w_early_nxt = 1'b0;
      end
    endcase
  end

  // State, counter, early flag and heartbeat sample registers.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state   <= ST_DISABLED;
      r_cnt     <= '0;
      r_early   <= 1'b0;
      r_hb_prev <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_early   <= w_early_nxt;
      r_hb_prev <= i_heartbeat;
    end
  end

  assign o_warning     = (r_state == ST_WARN);
  assign o_triggered   = (r_state == ST_TRIPPED);
  assign o_early_fault = r_early;

endmodule

// File: rtl/multi_channel_watchdog.sv
// -----------------------------------------------------------------------------
// multi_channel_watchdog
// N_CH independent watchdog channels plus a masked system reset request.
// Ports:
//   clk         : system clock, rising edge
//   rstn        : synchronous active-low reset
//   enable      : [N_CH] per-channel enable
//   heartbeat   : [N_CH] per-channel kick (rising edge)
//   clear       : [N_CH] per-channel trip clear
//   warning     : [N_CH] channel in warning band
//   triggered   : [N_CH] channel tripped (sticky until clear/reset)
//   early_fault : [N_CH] trip caused by a window violation
//   force_reset : OR of tripped channels selected by FR_MASK
// -----------------------------------------------------------------------------
module multi_channel_watchdog
  import wd_pkg::*;
#(
  parameter int unsigned         N_CH        = 4,
  parameter int unsigned         CNT_W       = 32,
  parameter int unsigned         TIMEOUT     = 1000,
  parameter int unsigned         WARN_THRESH = 800,
  parameter int unsigned         WINDOW_MIN  = 0,
  parameter logic [N_CH-1:0]     FR_MASK     = {N_CH{1'b1}}
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [N_CH-1:0] enable,
  input  logic [N_CH-1:0] heartbeat,
  input  logic [N_CH-1:0] clear,
  output logic [N_CH-1:0] warning,
  output logic [N_CH-1:0] triggered,
  output logic [N_CH-1:0] early_fault,
  output logic            force_reset
);

  if (!wd_params_ok(N_CH, CNT_W, TIMEOUT, WARN_THRESH, WINDOW_MIN)) begin : g_bad_params
    $error("multi_channel_watchdog: illegal parameter combination");
  end

  logic [N_CH-1:0] w_warning;
  logic [N_CH-1:0] w_triggered;
  logic [N_CH-1:0] w_early;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    wd_channel #(
      .CNT_W      (CNT_W),
      .TIMEOUT    (TIMEOUT),
      .WARN_THRESH(WARN_THRESH),
      .WINDOW_MIN (WINDOW_MIN)
    ) u_ch (
      .i_clk        (clk),
      .i_rstn       (rstn),
      .i_enable     (enable[g]),
      .i_heartbeat  (heartbeat[g]),
      .i_clear      (clear[g]),
      .o_warning    (w_warning[g]),
      .o_triggered  (w_triggered[g]),
      .o_early_fault(w_early[g])
    );
  end

  assign warning     = w_warning;
  assign triggered   = w_triggered;
  assign early_fault = w_early;
  // Decoded straight from registered channel state: no extra cycle of delay.
  assign force_reset = |(w_triggered & FR_MASK);

endmodule

// File: tb/tb_multi_channel_watchdog.sv
// -----------------------------------------------------------------------------
// tb_multi_channel_watchdog
// Directed bench for multi_channel_watchdog with three configurations
// (N_CH=2, TIMEOUT=8, WARN_THRESH=6):
//   dut_a : WINDOW_MIN=0, FR_MASK=2'b11
//   dut_b : WINDOW_MIN=3
//   dut_c : FR_MASK=2'b01
// Cycle k means the state right after the k-th rising edge with rstn=1.
// -----------------------------------------------------------------------------
module tb_multi_channel_watchdog;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn_a, rstn_b, rstn_c;
  logic [1:0] en_a, hb_a, clr_a, warn_a, trig_a, early_a;
  logic [1:0] en_b, hb_b, clr_b, warn_b, trig_b, early_b;
  logic [1:0] en_c, hb_c, clr_c, warn_c, trig_c, early_c;
  logic       fr_a, fr_b, fr_c;

  int n_checks = 0;
  int n_errors = 0;

  multi_channel_watchdog #(.N_CH(2), .CNT_W(8), .TIMEOUT(8), .WARN_THRESH(6),
                           .WINDOW_MIN(0), .FR_MASK(2'b11)) dut_a (
    .clk(clk), .rstn(rstn_a), .enable(en_a), .heartbeat(hb_a), .clear(clr_a),
    .warning(warn_a), .triggered(trig_a), .early_fault(early_a), .force_reset(fr_a));

  multi_channel_watchdog #(.N_CH(2), .CNT_W(8), .TIMEOUT(8), .WARN_THRESH(6),
                           .WINDOW_MIN(3), .FR_MASK(2'b11)) dut_b (
    .clk(clk), .rstn(rstn_b), .enable(en_b), .heartbeat(hb_b), .clear(clr_b),
    .warning(warn_b), .triggered(trig_b), .early_fault(early_b), .force_reset(fr_b));

  multi_channel_watchdog #(.N_CH(2), .CNT_W(8), .TIMEOUT(8), .WARN_THRESH(6),
                           .WINDOW_MIN(0), .FR_MASK(2'b01)) dut_c (
    .clk(clk), .rstn(rstn_c), .enable(en_c), .heartbeat(hb_c), .clear(clr_c),
    .warning(warn_c), .triggered(trig_c), .early_fault(early_c), .force_reset(fr_c));

  // Compare one observed value against its expected value.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Channel restarted with counter 0 at cycle r: warning in r+6..r+7.
  function automatic logic exp_w(input int k, input int r);
    return (k == r + 6) || (k == r + 7);
  endfunction

  // Channel restarted with counter 0 at cycle r: tripped from r+8.
  function automatic logic exp_t(input int k, input int r);
    return (k >= r + 8);
  endfunction

  // Directed stimulus and checks.
  initial begin
    rstn_a = 1'b0; en_a = 2'b00; hb_a = 2'b00; clr_a = 2'b00;
    rstn_b = 1'b0; en_b = 2'b00; hb_b = 2'b00; clr_b = 2'b00;
    rstn_c = 1'b0; en_c = 2'b00; hb_c = 2'b00; clr_c = 2'b00;
    tick();
    tick();
    chk("rst_warn", {30'd0, warn_a}, 32'd0);
    chk("rst_trig", {30'd0, trig_a}, 32'd0);
    chk("rst_early", {30'd0, early_a}, 32'd0);
    chk("rst_fr", {31'd0, fr_a}, 32'd0);

    // Free-running timeout on channel 0.
    rstn_a = 1'b1;
    en_a   = 2'b01;
    for (int k = 0; k <= 11; k++) begin
      tick();
      chk($sformatf("a1_warn_c%0d", k), {30'd0, warn_a}, {31'd0, exp_w(k, 0)});
      chk($sformatf("a1_trig_c%0d", k), {30'd0, trig_a}, {31'd0, exp_t(k, 0)});
      chk($sformatf("a1_fr_c%0d", k), {31'd0, fr_a}, {31'd0, exp_t(k, 0)});
    end

    // Clear together with a kick; heartbeat then held high (one kick only).
    clr_a = 2'b01;
    hb_a  = 2'b01;
    tick();
    chk("clr_trig_c12", {30'd0, trig_a}, 32'd0);
    chk("clr_fr_c12", {31'd0, fr_a}, 32'd0);
    clr_a = 2'b00;
    for (int k = 13; k <= 20; k++) begin
      tick();
      chk($sformatf("clr_warn_c%0d", k), {30'd0, warn_a}, {31'd0, exp_w(k, 12)});
      chk($sformatf("clr_trig_c%0d", k), {30'd0, trig_a}, {31'd0, exp_t(k, 12)});
    end

    // Reset while tripped discards everything.
    rstn_a = 1'b0;
    tick();
    chk("rst_trip_trig", {30'd0, trig_a}, 32'd0);
    chk("rst_trip_warn", {30'd0, warn_a}, 32'd0);
    chk("rst_trip_fr", {31'd0, fr_a}, 32'd0);

    // Kick on the last counting cycle wins over the trip.
    hb_a   = 2'b00;
    rstn_a = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      tick();
    end
    chk("kick_warn_c7", {30'd0, warn_a}, 32'd1);
    hb_a = 2'b01;
    tick();
    chk("kick_warn_c8", {30'd0, warn_a}, 32'd0);
    chk("kick_trig_c8", {30'd0, trig_a}, 32'd0);
    hb_a = 2'b00;
    for (int k = 9; k <= 16; k++) begin
      tick();
      chk($sformatf("kick_warn_c%0d", k), {30'd0, warn_a}, {31'd0, exp_w(k, 8)});
      chk($sformatf("kick_trig_c%0d", k), {30'd0, trig_a}, {31'd0, exp_t(k, 8)});
    end

    // Enable low for cycles 6-7 on channel 1, then back on.
    rstn_a = 1'b0;
    en_a   = 2'b00;
    tick();
    rstn_a = 1'b1;
    en_a   = 2'b10;
    for (int k = 0; k <= 5; k++) begin
      tick();
    end
    en_a = 2'b00;
    tick();
    chk("dis_warn_c6", {30'd0, warn_a}, 32'd0);
    tick();
    chk("dis_warn_c7", {30'd0, warn_a}, 32'd0);
    en_a = 2'b10;
    for (int k = 8; k <= 16; k++) begin
      tick();
      chk($sformatf("dis_warn_c%0d", k), {30'd0, warn_a}, {30'd0, exp_w(k, 8), 1'b0});
      chk($sformatf("dis_trig_c%0d", k), {30'd0, trig_a}, {30'd0, exp_t(k, 8), 1'b0});
    end

    // Window mode: early kick trips, kick at counter 3 is accepted.
    rstn_b = 1'b1;
    en_b   = 2'b01;
    tick();
    tick();
    chk("win_trig_c1", {30'd0, trig_b}, 32'd0);
    hb_b = 2'b01;
    tick();
    chk("win_trig_c2", {30'd0, trig_b}, 32'd1);
    chk("win_early_c2", {30'd0, early_b}, 32'd1);
    chk("win_fr_c2", {31'd0, fr_b}, 32'd1);
    hb_b  = 2'b00;
    clr_b = 2'b01;
    tick();
    chk("win_trig_c3", {30'd0, trig_b}, 32'd0);
    chk("win_early_c3", {30'd0, early_b}, 32'd0);
    clr_b = 2'b00;
    tick();
    tick();
    tick();
    hb_b = 2'b01;
    tick();
    chk("win_trig_c7", {30'd0, trig_b}, 32'd0);
    chk("win_early_c7", {30'd0, early_b}, 32'd0);
    hb_b = 2'b00;
    for (int k = 8; k <= 15; k++) begin
      tick();
      chk($sformatf("win_warn_c%0d", k), {30'd0, warn_b}, {31'd0, exp_w(k, 7)});
      chk($sformatf("win_trig_c%0d", k), {30'd0, trig_b}, {31'd0, exp_t(k, 7)});
    end
    chk("win_early_c15", {30'd0, early_b}, 32'd0);

    // Force-reset mask: channel 1 trips first (masked), channel 0 later.
    rstn_c = 1'b1;
    en_c   = 2'b10;
    for (int k = 0; k <= 12; k++) begin
      if (k == 4) begin
        en_c = 2'b11;
      end else begin
        en_c = en_c;
      end
      tick();
      chk($sformatf("mask_trig_c%0d", k), {30'd0, trig_c}, {30'd0, exp_t(k, 0), exp_t(k, 4)});
      chk($sformatf("mask_fr_c%0d", k), {31'd0, fr_c}, {31'd0, exp_t(k, 4)});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
